spram_bank_ring: RTL and testbench

//  Parametrised N-bank SPRAM frame buffer; successor to the fixed two-bank ping-pong capture buffer.

---
 rtl/spram_bank_ring.sv | 130 +++++++++++++
 tb/tb_spram_bank_ring.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bank_ring.sv
// N-bank SPRAM frame ring: capture fills whole frames into banks round-robin,
// the reader drains the oldest completed bank and then hands it back.
module spram_bank_ring #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 16384
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iWr_Valid,
    input  logic              iWr_SOF,
    input  logic [DATA_W-1:0] iWr_Data,
    output logic              oWr_Ready,
    input  logic              iRd_En,
    input  logic [ADDR_W-1:0] iRd_Addr,
    input  logic              iRd_Done,
    output logic              oRd_Avail,
    output logic [1:0]        oRd_Bank,
    output logic [DATA_W-1:0] oRd_Data,
    output logic              oRd_Valid,
    output logic [2:0]        oFull_Cnt,
    output logic [15:0]       oOvf_Cnt
);
    localparam int PTR_W = (NUM_BANKS > 2) ? 2 : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bankState_t;
    typedef enum logic {W_IDLE, W_FILL} wrState_t;

    bankState_t        bankState [NUM_BANKS];
    wrState_t          wrState;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  rdSel;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] wrAddrSel;
    logic              wrAccept;
    logic              wrLast;
    logic [DATA_W-1:0] bankDout [NUM_BANKS];

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign oWr_Ready = (wrState == W_FILL) || (bankState[wrPtr] == B_FREE);
    // Outside a frame only an SOF word starts a write; stray words are dropped silently.
    assign wrAccept  = iWr_Valid && oWr_Ready && ((wrState == W_FILL) || iWr_SOF);
    assign wrAddrSel = iWr_SOF ? '0 : wrAddr;
    assign wrLast    = (wrAddrSel == LAST_ADDR);

    assign oRd_Avail = (bankState[rdPtr] == B_READING);
    assign oRd_Bank  = 2'(rdPtr);
    assign oRd_Data  = oRd_Valid ? bankDout[rdSel] : '0;

    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
        oFull_Cnt = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bankState[i] == B_FULL || bankState[i] == B_READING) begin
                oFull_Cnt = oFull_Cnt + 3'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bankState[i] <= B_FREE;
            end
            wrState   <= W_IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            rdSel     <= '0;
            wrAddr    <= '0;
            oOvf_Cnt  <= '0;
            oRd_Valid <= 1'b0;
        end else begin
            if (iWr_Valid && !oWr_Ready && (oOvf_Cnt != 16'hFFFF)) begin
                oOvf_Cnt <= oOvf_Cnt + 16'd1;
            end
            if (wrAccept) begin
                if (wrLast) begin
                    bankState[wrPtr] <= B_FULL;
                    wrPtr            <= nextPtr(wrPtr);
                    wrState          <= W_IDLE;
                end else begin
                    bankState[wrPtr] <= B_FILLING;
                    wrAddr           <= wrAddrSel + ADDR_W'(1);
                    wrState          <= W_FILL;
                end
            end

            // Writer only touches FREE/FILLING banks, reader only FULL/READING ones.
            oRd_Valid <= iRd_En && oRd_Avail;
            if (iRd_En && oRd_Avail) begin
                rdSel <= rdPtr;
            end
            if (bankState[rdPtr] == B_FULL) begin
                bankState[rdPtr] <= B_READING;
            end else if (oRd_Avail && iRd_Done) begin
                bankState[rdPtr] <= B_FREE;
                rdPtr            <= nextPtr(rdPtr);
            end
        end
    end

    // One single-port RAM per bank: CS tied high, all nibbles write-enabled.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [2**ADDR_W];
        logic [DATA_W-1:0] dout;
        logic              we;
        logic [ADDR_W-1:0] addr;

        assign we   = wrAccept && (wrPtr == PTR_W'(b));
        assign addr = we ? wrAddrSel : iRd_Addr;

        // NOTE: the RAM array and its output register have no reset; contents survive iRst.
        always_ff @(posedge iClk) begin
            if (we) begin
                mem[addr] <= iWr_Data;
            end
            dout <= mem[addr];
        end

        assign bankDout[b] = dout;
    end

endmodule

// File: tb/tb_spram_bank_ring.sv
// Bench for spram_bank_ring: directed scenarios plus randomized traffic checked against a frame-queue model.
module tb_spram_bank_ring;
    localparam int NB = 4;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int FL = 8;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iWr_Valid = 1'b0, iWr_SOF = 1'b0, iRd_En = 1'b0, iRd_Done = 1'b0;
    logic [DW-1:0] iWr_Data = '0;
    logic [AW-1:0] iRd_Addr = '0;

    logic          wrReady, rdAvail, rdValid;
    logic [1:0]    rdBank;
    logic [DW-1:0] rdData;
    logic [2:0]    fullCnt;
    logic [15:0]   ovfCnt;

    logic          wrReady2, rdAvail2, rdValid2;
    logic [1:0]    rdBank2;
    logic [DW-1:0] rdData2;
    logic [2:0]    fullCnt2;
    logic [15:0]   ovfCnt2;

    int errors = 0;
    int checks = 0;

    spram_bank_ring #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL)) u4 (
        .iClk(iClk), .iRst(iRst), .iWr_Valid(iWr_Valid), .iWr_SOF(iWr_SOF), .iWr_Data(iWr_Data),
        .oWr_Ready(wrReady), .iRd_En(iRd_En), .iRd_Addr(iRd_Addr), .iRd_Done(iRd_Done),
        .oRd_Avail(rdAvail), .oRd_Bank(rdBank), .oRd_Data(rdData), .oRd_Valid(rdValid),
        .oFull_Cnt(fullCnt), .oOvf_Cnt(ovfCnt)
    );

    spram_bank_ring #(.NUM_BANKS(2), .ADDR_W(AW), .DATA_W(DW), .FRAME_LEN(FL)) u2 (
        .iClk(iClk), .iRst(iRst), .iWr_Valid(iWr_Valid), .iWr_SOF(iWr_SOF), .iWr_Data(iWr_Data),
        .oWr_Ready(wrReady2), .iRd_En(iRd_En), .iRd_Addr(iRd_Addr), .iRd_Done(iRd_Done),
        .oRd_Avail(rdAvail2), .oRd_Bank(rdBank2), .oRd_Data(rdData2), .oRd_Valid(rdValid2),
        .oFull_Cnt(fullCnt2), .oOvf_Cnt(ovfCnt2)
    );

    always #5 iClk = ~iClk;

    // Reference model of the 4-bank instance: queue of completed, unreleased banks in order.
    int            mQ[$];
    bit            mAvail, mFilling, mExpValid;
    int            mNextWr, mWaddr, mRel, mOvf;
    logic [DW-1:0] mMem [NB][1<<AW];
    logic [DW-1:0] mExpData;

    function automatic bit m_ready();
        if (mFilling) return 1'b1;
        foreach (mQ[i]) if (mQ[i] == mNextWr) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        mQ.delete();
        mAvail = 0; mFilling = 0; mExpValid = 0;
        mNextWr = 0; mWaddr = 0; mRel = 0; mOvf = 0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [DW-1:0] d,
                              input logic en, input logic [AW-1:0] a, input logic dn);
        bit rdy  = m_ready();
        bit rel  = mAvail && dn;
        bit gain = !mAvail && (mQ.size() > 0);
        int addr;
        mExpValid = mAvail && en;
        if (mExpValid) mExpData = mMem[mQ[0]][a];
        if (rel) begin
            void'(mQ.pop_front());
            mAvail = 0;
            mRel++;
        end else if (gain) begin
            mAvail = 1;
        end
        if (v) begin
            if (!rdy) begin
                if (mOvf < 65535) mOvf++;
            end else if (mFilling || s) begin
                addr = s ? 0 : mWaddr;
                mMem[mNextWr][addr] = d;
                if (addr == FL - 1) begin
                    mQ.push_back(mNextWr);
                    mNextWr  = (mNextWr + 1) % NB;
                    mFilling = 0;
                end else begin
                    mFilling = 1;
                    mWaddr   = addr + 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic s, input logic [DW-1:0] d,
                         input logic en, input logic [AW-1:0] a, input logic dn);
        iWr_Valid = v; iWr_SOF = s; iWr_Data = d; iRd_En = en; iRd_Addr = a; iRd_Done = dn;
        @(posedge iClk);
        model_step(v, s, d, en, a, dn);
        @(negedge iClk);
        iWr_Valid = 0; iWr_SOF = 0; iRd_En = 0; iRd_Done = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, '0, 0, '0, 0);
    endtask

    task automatic send_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FL; i++) cycle(1, i == 0, base + DW'(i), 0, '0, 0);
    endtask

    task automatic apply_reset();
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        model_reset();
        repeat (2) @(negedge iClk);
        checks++;
        if ({wrReady, rdAvail, rdBank, rdValid, rdData, fullCnt, ovfCnt} !== {1'b1, 1'b0, 2'd0, 1'b0, 16'd0, 3'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_state4 got=%h expected=%h", {wrReady, rdAvail, rdBank, rdValid, rdData, fullCnt, ovfCnt}, {1'b1, 39'd0});
        end
        checks++;
        if ({wrReady2, rdAvail2, rdBank2, rdValid2, rdData2, fullCnt2, ovfCnt2} !== {1'b1, 39'd0}) begin
            errors++;
            $display("FAIL reset_state2 got=%h expected=%h", {wrReady2, rdAvail2, rdBank2, rdValid2, rdData2, fullCnt2, ovfCnt2}, {1'b1, 39'd0});
        end
        iRst = 1'b0;
    endtask

    task automatic test_no_sof();
        for (int i = 0; i < 5; i++) cycle(1, 0, DW'(16'h0C00 + i), 0, '0, 0);
        checks++;
        if ({fullCnt, ovfCnt, wrReady, rdAvail} !== {3'd0, 16'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL no_sof_4 got full=%0d ovf=%0d ready=%b avail=%b expected 0 0 1 0", fullCnt, ovfCnt, wrReady, rdAvail);
        end
        checks++;
        if ({fullCnt2, ovfCnt2, wrReady2, rdAvail2} !== {3'd0, 16'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL no_sof_2 got full=%0d ovf=%0d ready=%b avail=%b expected 0 0 1 0", fullCnt2, ovfCnt2, wrReady2, rdAvail2);
        end
    endtask

    task automatic test_two_bank();
        send_frame(16'h0000);
        checks++;
        if (fullCnt !== 3'd1 || fullCnt2 !== 3'd1 || rdAvail !== 1'b0) begin
            errors++;
            $display("FAIL first_full got full4=%0d full2=%0d avail=%b expected 1 1 0", fullCnt, fullCnt2, rdAvail);
        end
        idle(1);
        checks++;
        if ({rdAvail, rdBank, rdAvail2, rdBank2} !== {1'b1, 2'd0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL first_avail got avail4=%b bank4=%0d avail2=%b bank2=%0d expected 1 0 1 0", rdAvail, rdBank, rdAvail2, rdBank2);
        end
        cycle(0, 0, '0, 1, 4'd5, 0);
        checks++;
        if ({rdValid, rdData, rdValid2, rdData2} !== {1'b1, 16'd5, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL first_read got v4=%b d4=%h v2=%b d2=%h expected 1 0005", rdValid, rdData, rdValid2, rdData2);
        end
        cycle(0, 0, '0, 0, '0, 1);
        send_frame(16'h0010);
        send_frame(16'h0020);
        checks++;
        if ({fullCnt2, wrReady2, fullCnt, wrReady} !== {3'd2, 1'b0, 3'd2, 1'b1}) begin
            errors++;
            $display("FAIL two_bank_backpressure got full2=%0d ready2=%b full4=%0d ready4=%b expected 2 0 2 1", fullCnt2, wrReady2, fullCnt, wrReady);
        end
        cycle(0, 0, '0, 1, 4'd7, 0);
        checks++;
        if ({rdBank, rdBank2, rdData, rdData2} !== {2'd1, 2'd1, 16'h0017, 16'h0017}) begin
            errors++;
            $display("FAIL second_read got bank4=%0d bank2=%0d d4=%h d2=%h expected 1 1 0017", rdBank, rdBank2, rdData, rdData2);
        end
        cycle(0, 0, '0, 0, '0, 1);
        idle(1);
        cycle(0, 0, '0, 1, 4'd3, 0);
        checks++;
        if ({rdBank, rdBank2, rdValid2, rdData, rdData2} !== {2'd2, 2'd0, 1'b1, 16'h0023, 16'h0023}) begin
            errors++;
            $display("FAIL wrap_read got bank4=%0d bank2=%0d v2=%b d4=%h d2=%h expected 2 0 1 0023", rdBank, rdBank2, rdValid2, rdData, rdData2);
        end
        cycle(0, 0, '0, 0, '0, 1);
        checks++;
        if ({fullCnt, fullCnt2, wrReady2} !== {3'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL drained got full4=%0d full2=%0d ready2=%b expected 0 0 1", fullCnt, fullCnt2, wrReady2);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int f = 1; f <= 4; f++) send_frame(DW'(f * 256));
        for (int i = 0; i < 10; i++) cycle(1, i == 0, DW'(16'hEE00 + i), 0, '0, 0);
        checks++;
        if ({fullCnt, wrReady, ovfCnt} !== {3'd4, 1'b0, 16'd10}) begin
            errors++;
            $display("FAIL overflow got full=%0d ready=%b ovf=%0d expected 4 0 10", fullCnt, wrReady, ovfCnt);
        end
        cycle(0, 0, '0, 0, '0, 1);
        checks++;
        if ({wrReady, fullCnt} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL release_ready got ready=%b full=%0d expected 1 3", wrReady, fullCnt);
        end
        send_frame(16'h0500);
        checks++;
        if ({fullCnt, wrReady} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL refill got full=%0d ready=%b expected 4 0", fullCnt, wrReady);
        end
        for (int k = 1; k <= 3; k++) begin
            idle(1);
            checks++;
            if ({rdAvail, rdBank} !== {1'b1, 2'(k)}) begin
                errors++;
                $display("FAIL drain_order got avail=%b bank=%0d expected 1 %0d", rdAvail, rdBank, k);
            end
            cycle(0, 0, '0, 0, '0, 1);
        end
        idle(1);
        cycle(0, 0, '0, 1, 4'd6, 0);
        checks++;
        if ({rdBank, rdValid, rdData} !== {2'd0, 1'b1, 16'h0506}) begin
            errors++;
            $display("FAIL wrap_bank0 got bank=%0d v=%b d=%h expected 0 1 0506", rdBank, rdValid, rdData);
        end
        cycle(0, 0, '0, 0, '0, 1);
    endtask

    task automatic test_sof_restart();
        logic [AW-1:0] addrs [4];
        addrs = '{4'd0, 4'd1, 4'd2, 4'd7};
        for (int i = 0; i < 3; i++) cycle(1, i == 0, DW'(16'hBB00 + i), 0, '0, 0);
        send_frame(16'hAA00);
        idle(1);
        checks++;
        if ({rdAvail, rdBank, fullCnt} !== {1'b1, 2'd1, 3'd1}) begin
            errors++;
            $display("FAIL restart_avail got avail=%b bank=%0d full=%0d expected 1 1 1", rdAvail, rdBank, fullCnt);
        end
        foreach (addrs[i]) begin
            cycle(0, 0, '0, 1, addrs[i], 0);
            checks++;
            if ({rdValid, rdData} !== {1'b1, 16'hAA00 + 16'(addrs[i])}) begin
                errors++;
                $display("FAIL restart_data addr=%0d got v=%b d=%h expected 1 %h", addrs[i], rdValid, rdData, 16'hAA00 + 16'(addrs[i]));
            end
        end
        cycle(0, 0, '0, 0, '0, 1);
    endtask

    task automatic test_random();
        logic [23:0] expV;
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom % 4) != 0, ($urandom % 10) == 0, DW'($urandom),
                  ($urandom % 2) == 0, AW'($urandom_range(0, FL - 1)), ($urandom % 12) == 0);
            expV = {m_ready(), mAvail, 2'(mRel % NB), mExpValid, 3'(mQ.size()), 16'(mOvf)};
            checks++;
            if ({wrReady, rdAvail, rdBank, rdValid, fullCnt, ovfCnt} !== expV) begin
                errors++;
                $display("FAIL rand_status cyc=%0d got=%h expected=%h", c, {wrReady, rdAvail, rdBank, rdValid, fullCnt, ovfCnt}, expV);
            end
            if (mExpValid) begin
                checks++;
                if (rdData !== mExpData) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got=%h expected=%h", c, rdData, mExpData);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send_frame(16'h0600);
        idle(1);
        cycle(1, 1, 16'h0700, 1, 4'd2, 0);
        cycle(1, 0, 16'h0701, 1, 4'd3, 0);
        checks++;
        if ({rdValid, rdData} !== {1'b1, 16'h0603}) begin
            errors++;
            $display("FAIL mid_read got v=%b d=%h expected 1 0603", rdValid, rdData);
        end
        #2 iRst = 1'b1;
        #1;
        checks++;
        if ({wrReady, rdAvail, rdBank, rdValid, rdData, fullCnt, ovfCnt} !== {1'b1, 39'd0}) begin
            errors++;
            $display("FAIL async_reset4 got=%h expected=%h", {wrReady, rdAvail, rdBank, rdValid, rdData, fullCnt, ovfCnt}, {1'b1, 39'd0});
        end
        checks++;
        if ({wrReady2, rdAvail2, rdBank2, rdValid2, rdData2, fullCnt2, ovfCnt2} !== {1'b1, 39'd0}) begin
            errors++;
            $display("FAIL async_reset2 got=%h expected=%h", {wrReady2, rdAvail2, rdBank2, rdValid2, rdData2, fullCnt2, ovfCnt2}, {1'b1, 39'd0});
        end
        @(negedge iClk);
        iRst = 1'b0;
        model_reset();
        send_frame(16'h0800);
        idle(1);
        cycle(0, 0, '0, 1, 4'd4, 0);
        checks++;
        if ({rdBank, fullCnt, rdValid, rdData} !== {2'd0, 3'd1, 1'b1, 16'h0804}) begin
            errors++;
            $display("FAIL post_reset_bank0 got bank=%0d full=%0d v=%b d=%h expected 0 1 1 0804", rdBank, fullCnt, rdValid, rdData);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_no_sof();
        test_two_bank();
        test_overflow();
        test_sof_restart();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
